// File: rtl/frog_pkg.sv
// Shared definitions for the frog game controller and car generator:
// controller state encoding, start-position helpers, default grid size.
package frog_pkg;

  localparam int DEF_GRID_COLS = 20;
  localparam int DEF_GRID_ROWS = 15;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_HIT       = 2'd1,
    ST_GAME_OVER = 2'd2
  } frog_state_e;

  function automatic int start_col(input int cols);
    return cols / 2;
  endfunction

  function automatic int start_row(input int rows);
    return rows - 1;
  endfunction

endpackage

// File: rtl/frog_hit_detect.sv
// Combinational car/frog overlap detector.
// Ports: packed car columns/rows, frog col/row in; hit out.
module frog_hit_detect
  import frog_pkg::*;
#(
  parameter int GRID_COLS = DEF_GRID_COLS,
  parameter int GRID_ROWS = DEF_GRID_ROWS,
  parameter int NUM_CARS  = 16,
  parameter int COL_W     = $clog2(GRID_COLS),
  parameter int ROW_W     = $clog2(GRID_ROWS)
) (
  input  logic [NUM_CARS*COL_W-1:0] car_x_flat,
  input  logic [NUM_CARS*ROW_W-1:0] car_y_flat,
  input  logic [COL_W-1:0]          frog_col,
  input  logic [ROW_W-1:0]          frog_row,
  output logic                      hit
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(GRID_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(GRID_ROWS - 1);

  logic [NUM_CARS-1:0] match;

  for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
    logic [COL_W-1:0] cx;
    logic [ROW_W-1:0] cy;
    assign cx = car_x_flat[i*COL_W +: COL_W];
    assign cy = car_y_flat[i*ROW_W +: ROW_W];
    // Off-grid cars are parked, never a hit.
    assign match[i] = (cx == frog_col) && (cy == frog_row)
                   && (cx <= COL_MAX) && (cy <= ROW_MAX);
  end

  assign hit = |match;

endmodule

// File: rtl/frog_ctrl_gen.sv
// Frog game controller: movement, collisions, lives, levels, game over.
// Ports: clk/reset, 4 buttons, restart, car positions in; frog state out.
module frog_ctrl_gen
  import frog_pkg::*;
#(
  parameter int GRID_COLS     = DEF_GRID_COLS,
  parameter int GRID_ROWS     = DEF_GRID_ROWS,
  parameter int NUM_CARS      = 16,
  parameter int MAX_LIVES     = 3,
  parameter int INVULN_CYCLES = 50_000_000,
  parameter int LEVEL_W       = 4,
  parameter int COL_W         = $clog2(GRID_COLS),
  parameter int ROW_W         = $clog2(GRID_ROWS),
  parameter int LIVES_W       = $clog2(MAX_LIVES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btn_left,
  input  logic                      btn_down,
  input  logic                      btn_up,
  input  logic                      btn_right,
  input  logic                      restart,
  input  logic [NUM_CARS*COL_W-1:0] car_x_flat,
  input  logic [NUM_CARS*ROW_W-1:0] car_y_flat,
  output logic [COL_W-1:0]          frog_col,
  output logic [ROW_W-1:0]          frog_row,
  output logic [LIVES_W-1:0]        lives,
  output logic [LEVEL_W-1:0]        level,
  output logic                      collision_pulse,
  output logic                      level_up_pulse,
  output logic                      invuln,
  output logic                      game_over
);

  localparam int CNT_W =
    (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;

  localparam logic [COL_W-1:0] START_COL =
    COL_W'(start_col(GRID_COLS));
  localparam logic [ROW_W-1:0] START_ROW =
    ROW_W'(start_row(GRID_ROWS));
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(GRID_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(GRID_ROWS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INVULN_CYCLES - 1);

  frog_state_e        state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               block_q, block_d;
  logic               cpulse_q, cpulse_d;
  logic               lpulse_q, lpulse_d;
  logic               inv_q, inv_d;
  logic               go_q, go_d;

  logic hit;
  logic any_btn;

  frog_hit_detect #(
    .GRID_COLS (GRID_COLS),
    .GRID_ROWS (GRID_ROWS),
    .NUM_CARS  (NUM_CARS),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W)
  ) u_hit (
    .car_x_flat (car_x_flat),
    .car_y_flat (car_y_flat),
    .frog_col   (col_q),
    .frog_row   (row_q),
    .hit        (hit)
  );

  assign any_btn = btn_left | btn_down | btn_up | btn_right;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    lives_d  = lives_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    block_d  = block_q;
    cpulse_d = 1'b0;
    lpulse_d = 1'b0;
    // Re-arm once every button has been released.
    if (!any_btn) block_d = 1'b0;
    if (restart) begin
      state_d = ST_PLAY;
      col_d   = START_COL;
      row_d   = START_ROW;
      lives_d = LIVES_INIT;
      level_d = '0;
      cnt_d   = '0;
      block_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          if (hit) begin
            lives_d  = lives_q - LIVES_W'(1);
            col_d    = START_COL;
            row_d    = START_ROW;
            cpulse_d = 1'b1;
            if (lives_d == '0) begin
              state_d = ST_GAME_OVER;
            end else begin
              state_d = ST_HIT;
              cnt_d   = CNT_INIT;
            end
          end else if (row_q == '0) begin
            lpulse_d = 1'b1;
            if (level_q != '1) level_d = level_q + LEVEL_W'(1);
            col_d = START_COL;
            row_d = START_ROW;
          end else if (!block_q && any_btn) begin
            // Edge presses still consume the press.
            block_d = 1'b1;
            if (btn_left) begin
              if (col_q != '0) col_d = col_q - COL_W'(1);
            end else if (btn_down) begin
              if (row_q != ROW_MAX) row_d = row_q + ROW_W'(1);
            end else if (btn_up) begin
              row_d = row_q - ROW_W'(1);
            end else begin
              if (col_q != COL_MAX) col_d = col_q + COL_W'(1);
            end
          end
        end
        ST_HIT: begin
          if (cnt_q == '0) state_d = ST_PLAY;
          else cnt_d = cnt_q - CNT_W'(1);
        end
        ST_GAME_OVER: begin
          col_d   = START_COL;
          row_d   = START_ROW;
          lives_d = '0;
        end
        default: state_d = ST_PLAY;
      endcase
    end
    inv_d = (state_d == ST_HIT);
    go_d  = (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_PLAY;
      col_q    <= START_COL;
      row_q    <= START_ROW;
      lives_q  <= LIVES_INIT;
      level_q  <= '0;
      cnt_q    <= '0;
      block_q  <= 1'b1;
      cpulse_q <= 1'b0;
      lpulse_q <= 1'b0;
      inv_q    <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      lives_q  <= lives_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      block_q  <= block_d;
      cpulse_q <= cpulse_d;
      lpulse_q <= lpulse_d;
      inv_q    <= inv_d;
      go_q     <= go_d;
    end
  end

  assign frog_col        = col_q;
  assign frog_row        = row_q;
  assign lives           = lives_q;
  assign level           = level_q;
  assign collision_pulse = cpulse_q;
  assign level_up_pulse  = lpulse_q;
  assign invuln          = inv_q;
  assign game_over       = go_q;

endmodule

// File: tb/tb_frog_ctrl_gen.sv
// Directed vector bench for frog_ctrl_gen.
// Short HIT window (8) and 2-bit level to reach saturation quickly.
module tb_frog_ctrl_gen;

  localparam int NC = 16;
  localparam logic [3:0] N = 4'b0000;
  localparam logic [3:0] L = 4'b1000;
  localparam logic [3:0] D = 4'b0100;
  localparam logic [3:0] U = 4'b0010;
  localparam logic [3:0] R = 4'b0001;

  typedef struct {
    logic [3:0] b;
    logic       rst;
    logic       rs;
    logic [4:0] cx;
    logic [3:0] cy;
    logic [4:0] col;
    logic [3:0] row;
    logic [1:0] lv;
    logic [1:0] lvl;
    logic       cp;
    logic       lp;
    logic       inv;
    logic       go;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_left = 1'b0, btn_down = 1'b0;
  logic btn_up = 1'b0, btn_right = 1'b0;
  logic restart = 1'b0;
  logic [NC*5-1:0] car_x_flat = '1;
  logic [NC*4-1:0] car_y_flat = '0;
  logic [4:0] frog_col;
  logic [3:0] frog_row;
  logic [1:0] lives;
  logic [1:0] level;
  logic collision_pulse, level_up_pulse, invuln, game_over;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  frog_ctrl_gen #(
    .NUM_CARS      (NC),
    .INVULN_CYCLES (8),
    .LEVEL_W       (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .btn_left        (btn_left),
    .btn_down        (btn_down),
    .btn_up          (btn_up),
    .btn_right       (btn_right),
    .restart         (restart),
    .car_x_flat      (car_x_flat),
    .car_y_flat      (car_y_flat),
    .frog_col        (frog_col),
    .frog_row        (frog_row),
    .lives           (lives),
    .level           (level),
    .collision_pulse (collision_pulse),
    .level_up_pulse  (level_up_pulse),
    .invuln          (invuln),
    .game_over       (game_over)
  );

  function automatic vec_t mk(
    input logic [3:0] b, input logic rst, input logic rs,
    input int cx, input int cy, input int col, input int row,
    input int lv, input int lvl, input logic cp, input logic lp,
    input logic inv, input logic go);
    vec_t v;
    v.b = b; v.rst = rst; v.rs = rs;
    v.cx = 5'(cx); v.cy = 4'(cy);
    v.col = 5'(col); v.row = 4'(row);
    v.lv = 2'(lv); v.lvl = 2'(lvl);
    v.cp = cp; v.lp = lp; v.inv = inv; v.go = go;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    logic [16:0] got, want;
    @(negedge clk);
    reset = v.rst;
    restart = v.rs;
    {btn_left, btn_down, btn_up, btn_right} = v.b;
    for (int i = 0; i < NC; i++) begin
      car_x_flat[i*5 +: 5] = (i == 3) ? v.cx : 5'd31;
      car_y_flat[i*4 +: 4] = (i == 3) ? v.cy : 4'd0;
    end
    @(posedge clk);
    #1;
    got = {frog_col, frog_row, lives, level,
           collision_pulse, level_up_pulse, invuln, game_over};
    want = {v.col, v.row, v.lv, v.lvl, v.cp, v.lp, v.inv, v.go};
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s vec %0d: got col=%0d row=%0d lives=%0d lvl=%0d cp=%b lp=%b inv=%b go=%b, want col=%0d row=%0d lives=%0d lvl=%0d cp=%b lp=%b inv=%b go=%b",
        nm, n_vec, frog_col, frog_row, lives, level,
        collision_pulse, level_up_pulse, invuln, game_over,
        v.col, v.row, v.lv, v.lvl, v.cp, v.lp, v.inv, v.go);
    end
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = mk(N, 1, 0, 31, 0, 10, 14, 3, 0, 0, 0, 0, 0);
    tbl[1]  = mk(N, 0, 0, 31, 0, 10, 14, 3, 0, 0, 0, 0, 0);
    tbl[2]  = mk(U, 0, 0, 31, 0, 10, 13, 3, 0, 0, 0, 0, 0);
    tbl[3]  = mk(U, 0, 0, 31, 0, 10, 13, 3, 0, 0, 0, 0, 0);
    tbl[4]  = mk(U, 0, 0, 31, 0, 10, 13, 3, 0, 0, 0, 0, 0);
    tbl[5]  = mk(N, 0, 0, 31, 0, 10, 13, 3, 0, 0, 0, 0, 0);
    tbl[6]  = mk(U, 0, 0, 31, 0, 10, 12, 3, 0, 0, 0, 0, 0);
    tbl[7]  = mk(N, 0, 0, 31, 0, 10, 12, 3, 0, 0, 0, 0, 0);
    tbl[8]  = mk(L | U, 0, 0, 31, 0, 9, 12, 3, 0, 0, 0, 0, 0);
    tbl[9]  = mk(N, 0, 0, 31, 0, 9, 12, 3, 0, 0, 0, 0, 0);
    tbl[10] = mk(D | U, 0, 0, 31, 0, 9, 13, 3, 0, 0, 0, 0, 0);
    tbl[11] = mk(N, 0, 0, 31, 0, 9, 13, 3, 0, 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) apply(tbl[i], "table");

    // walk to the left edge, then push against it
    for (int k = 1; k <= 9; k++) begin
      apply(mk(L, 0, 0, 31, 0, 9 - k, 13, 3, 0, 0, 0, 0, 0), "walk_l");
      apply(mk(N, 0, 0, 31, 0, 9 - k, 13, 3, 0, 0, 0, 0, 0), "walk_l");
    end
    apply(mk(L, 0, 0, 31, 0, 0, 13, 3, 0, 0, 0, 0, 0), "edge_l");
    apply(mk(L, 0, 0, 31, 0, 0, 13, 3, 0, 0, 0, 0, 0), "edge_hold");
    apply(mk(N, 0, 0, 31, 0, 0, 13, 3, 0, 0, 0, 0, 0), "edge_rel");

    // hit 1 with btn_right on the same cycle, 8-cycle immunity
    apply(mk(N, 1, 0, 10, 14, 10, 14, 3, 0, 0, 0, 0, 0), "rst_car");
    apply(mk(N, 0, 0, 31, 0, 10, 14, 3, 0, 0, 0, 0, 0), "idle");
    apply(mk(R, 0, 0, 10, 14, 10, 14, 2, 0, 1, 0, 1, 0), "hit1");
    for (int k = 0; k < 7; k++)
      apply(mk(R, 0, 0, 10, 14, 10, 14, 2, 0, 0, 0, 1, 0), "immune");
    apply(mk(N, 0, 0, 31, 0, 10, 14, 2, 0, 0, 0, 0, 0), "hit_end");
    apply(mk(N, 0, 0, 31, 0, 10, 14, 2, 0, 0, 0, 0, 0), "no_rehit");

    // hit 2
    apply(mk(N, 0, 0, 10, 14, 10, 14, 1, 0, 1, 0, 1, 0), "hit2");
    for (int k = 0; k < 7; k++)
      apply(mk(N, 0, 0, 31, 0, 10, 14, 1, 0, 0, 0, 1, 0), "immune2");
    apply(mk(N, 0, 0, 31, 0, 10, 14, 1, 0, 0, 0, 0, 0), "hit2_end");

    // hit 3 -> game over, inputs ignored, restart
    apply(mk(N, 0, 0, 10, 14, 10, 14, 0, 0, 1, 0, 0, 1), "hit3");
    apply(mk(U, 0, 0, 31, 0, 10, 14, 0, 0, 0, 0, 0, 1), "go_btn");
    apply(mk(N, 0, 0, 10, 14, 10, 14, 0, 0, 0, 0, 0, 1), "go_car");
    apply(mk(N, 0, 1, 31, 0, 10, 14, 3, 0, 0, 0, 0, 0), "restart");
    apply(mk(U, 0, 0, 31, 0, 10, 14, 3, 0, 0, 0, 0, 0), "rs_block");
    apply(mk(N, 0, 0, 31, 0, 10, 14, 3, 0, 0, 0, 0, 0), "rs_rel");
    apply(mk(U, 0, 0, 31, 0, 10, 13, 3, 0, 0, 0, 0, 0), "rs_move");
    apply(mk(N, 0, 0, 31, 0, 10, 13, 3, 0, 0, 0, 0, 0), "rs_move");

    // first level from row 13
    for (int r = 12; r >= 1; r--) begin
      apply(mk(U, 0, 0, 31, 0, 10, r, 3, 0, 0, 0, 0, 0), "climb");
      apply(mk(N, 0, 0, 31, 0, 10, r, 3, 0, 0, 0, 0, 0), "climb");
    end
    apply(mk(U, 0, 0, 31, 0, 10, 0, 3, 0, 0, 0, 0, 0), "top");
    apply(mk(N, 0, 0, 31, 0, 10, 14, 3, 1, 0, 1, 0, 0), "lvl_up");
    apply(mk(N, 0, 0, 31, 0, 10, 14, 3, 1, 0, 0, 0, 0), "lp_low");

    // levels 2, 3, then saturated at 3
    for (int lv = 2; lv <= 4; lv++) begin
      int prev, nxt;
      prev = lv - 1;
      nxt = (lv > 3) ? 3 : lv;
      for (int r = 13; r >= 1; r--) begin
        apply(mk(U, 0, 0, 31, 0, 10, r, 3, prev, 0, 0, 0, 0), "climb");
        apply(mk(N, 0, 0, 31, 0, 10, r, 3, prev, 0, 0, 0, 0), "climb");
      end
      apply(mk(U, 0, 0, 31, 0, 10, 0, 3, prev, 0, 0, 0, 0), "top");
      apply(mk(N, 0, 0, 31, 0, 10, 14, 3, nxt, 0, 1, 0, 0), "lvl_sat");
    end

    // reset mid-HIT aborts with no pulse
    apply(mk(N, 0, 0, 10, 14, 10, 14, 2, 3, 1, 0, 1, 0), "hit4");
    apply(mk(N, 1, 0, 10, 14, 10, 14, 3, 0, 0, 0, 0, 0), "rst_hit");
    apply(mk(N, 0, 0, 31, 0, 10, 14, 3, 0, 0, 0, 0, 0), "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
